// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 3-flop input synchroniser, mid-bit 3-sample
// majority vote, false-start rejection, optional parity, 1 or 2 stop bits.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 29,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs232,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MM1  = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_MP1  = CNT_W'(MID + 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic                 s1, s2, s3;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;
    logic                 done;
    logic                 fall;
    logic                 maj;
    logic                 decide;
    logic                 wrap;
    logic                 exp_par;

    // Majority of three samples: a single corrupted sample cannot flip the bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Stage: asynchronous pin into the clock domain, plus one delay for edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rs232;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall    = !s2 && s3;
    assign decide  = (cnt == CNT_MP1);
    assign wrap    = (cnt == CNT_LAST);
    assign maj     = maj3(samp_a, samp_b, s2);
    assign exp_par = (PARITY == 2) ? (^shreg) : ~(^shreg);
    assign busy    = (state != IDLE);

    // Capture the two early mid-bit samples; the third is s2 at the decision point.
    always_ff @(posedge clk) begin
        if (cnt == CNT_MM1) samp_a <= s2;
        if (cnt == CNT_MID) samp_b <= s2;
        shreg <= shreg_n;
    end

    // Next-state logic: baud counter, bit index, shift register and error flags.
    always_comb begin
        state_n = state;
        cnt_n   = wrap ? '0 : cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        perr_n  = perr;
        ferr_n  = ferr;
        done    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (fall) begin
                    state_n = START;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end
            START: begin
                if (decide && maj) begin
                    // Start bit did not hold low to mid-bit: treat it as a glitch.
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (wrap) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (decide) shreg_n = {maj, shreg[DATA_BITS-1:1]};
                if (wrap) begin
                    if (idx == LAST_DATA) begin
                        idx_n   = '0;
                        state_n = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            PAR: begin
                if (decide && (maj != exp_par)) perr_n = 1'b1;
                if (wrap) begin
                    state_n = STOP;
                    idx_n   = '0;
                end
            end
            STOP: begin
                if (decide) begin
                    if (!maj) ferr_n = 1'b1;
                    if (idx == LAST_STOP) begin
                        // Leave at mid-bit so a start edge half a bit later is seen.
                        state_n = IDLE;
                        cnt_n   = '0;
                        done    = 1'b1;
                    end
                end else if (wrap) begin
                    idx_n = idx + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // Stage: control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            perr  <= perr_n;
            ferr  <= ferr_n;
        end
    end

    // Stage: frame delivery; data and flags hold until the next completed frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= done;
            if (done) begin
                rx_data    <= shreg;
                parity_err <= perr_n;
                frame_err  <= ferr_n;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) fed from a
// table of frames plus hand-written sequences; a scoreboard per instance.
module tb_uart_rx_cfg;

    localparam int CPB = 29;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;

    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic val_a, val_b, val_c;
    logic pe_a, pe_b, pe_c;
    logic fe_a, fe_b, fe_c;
    logic busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .rst_n(rst_n), .rs232(line_a), .rx_data(data_a), .rx_valid(val_a),
        .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs232(line_b), .rx_data(data_b), .rx_valid(val_b),
        .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .rs232(line_c), .rx_data(data_c), .rx_valid(val_c),
        .parity_err(pe_c), .frame_err(fe_c), .busy(busy_c));

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         inst;
        logic [8:0] data;
        bit         flip_par;
        bit         noise;
        logic [8:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    exp_t q_a[$], q_b[$], q_c[$];
    int   checks = 0;
    int   failures = 0;
    int   vcnt[3];
    int   vcyc[3];
    logic prevv[3];
    int   start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int inst, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        case (inst)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0: line_a = v;
            1: line_b = v;
            default: line_c = v;
        endcase
    endtask

    // Compare one delivered frame against the head of its scoreboard queue.
    task automatic take(input int inst, input logic [8:0] d, input logic pe, input logic fe,
                        input logic bz);
        exp_t e;
        int   sz;
        string nm;
        nm = (inst == 0) ? "a" : (inst == 1) ? "b" : "c";
        sz = (inst == 0) ? q_a.size() : (inst == 1) ? q_b.size() : q_c.size();
        chk({nm, "_expected_frame_pending"}, 32'(sz != 0), 1);
        chk({nm, "_valid_one_cycle"}, 32'(prevv[inst]), 0);
        chk({nm, "_busy_at_valid"}, 32'(bz), 0);
        if (sz != 0) begin
            case (inst)
                0: e = q_a.pop_front();
                1: e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            chk({nm, "_rx_data"}, 32'(d), 32'(e.data));
            chk({nm, "_parity_err"}, 32'(pe), 32'(e.perr));
            chk({nm, "_frame_err"}, 32'(fe), 32'(e.ferr));
        end
    endtask

    // Drive one frame; abort_cyc >= 0 pulses reset at that cycle of the frame and stops.
    task automatic send_frame(input int inst, input logic [8:0] d, input int nbits,
                              input int par, input int nstop, input bit flip_par,
                              input logic [1:0] stops, input bit noise, input int abort_cyc);
        logic [15:0] bits;
        int          n;
        logic        x;
        logic        v;
        bits = '0;
        n = 1;
        x = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bits[n] = d[i];
            x = x ^ d[i];
            n++;
        end
        if (par != 0) begin
            bits[n] = ((par == 2) ? x : ~x) ^ flip_par;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[n] = stops[i];
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) start_cyc = cyc;
                if (abort_cyc >= 0 && b * CPB + c == abort_cyc) begin
                    rst_n = 1'b0;
                    set_line(inst, 1'b1);
                    @(negedge clk);
                    chk("rst_mid_rx_data", 32'(data_a), 0);
                    chk("rst_mid_rx_valid", 32'(val_a), 0);
                    chk("rst_mid_parity_err", 32'(pe_a), 0);
                    chk("rst_mid_frame_err", 32'(fe_a), 0);
                    chk("rst_mid_busy", 32'(busy_a), 0);
                    rst_n = 1'b1;
                    return;
                end
                v = bits[b];
                set_line(inst, (noise && c == 15) ? ~v : v);
            end
        end
    endtask

    vec_t vecs[7];
    int   base;
    bit   seen;
    int   lat;

    initial begin
        for (int i = 0; i < 3; i++) begin
            vcnt[i] = 0;
            vcyc[i] = 0;
            prevv[i] = 1'b0;
        end

        fork
            forever begin
                @(negedge clk);
                if (val_a) begin
                    vcnt[0]++;
                    vcyc[0] = cyc;
                    take(0, {1'b0, data_a}, pe_a, fe_a, busy_a);
                end
                if (val_b) begin
                    vcnt[1]++;
                    vcyc[1] = cyc;
                    take(1, {2'b0, data_b}, pe_b, fe_b, busy_b);
                end
                if (val_c) begin
                    vcnt[2]++;
                    vcyc[2] = cyc;
                    take(2, {1'b0, data_c}, pe_c, fe_c, busy_c);
                end
                prevv[0] = val_a;
                prevv[1] = val_b;
                prevv[2] = val_c;
            end
        join_none

        vecs[0] = '{0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h0FF, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0};
        vecs[3] = '{0, 9'h0C3, 1'b0, 1'b1, 9'h0C3, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h055, 1'b0, 1'b0, 9'h055, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h055, 1'b1, 1'b0, 9'h055, 1'b1, 1'b0};
        vecs[6] = '{1, 9'h02A, 1'b0, 1'b0, 9'h02A, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rx_data", 32'(data_a), 0);
        chk("reset_rx_valid", 32'(val_a), 0);
        chk("reset_parity_err", 32'(pe_a), 0);
        chk("reset_frame_err", 32'(fe_a), 0);
        chk("reset_busy", 32'(busy_a), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single 8N1 frame with latency window
        base = vcnt[0];
        push(0, 9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, 0, 1, 1'b0, 2'b11, 1'b0, -1);
        repeat (5) @(negedge clk);
        lat = vcyc[0] - start_cyc;
        chk("a5_valid_count", 32'(vcnt[0] - base), 1);
        chk("a5_latency_in_279_283", 32'(lat >= 279 && lat <= 283), 1);
        chk("a5_busy_after", 32'(busy_a), 0);

        // Table: back-to-back frames, noisy frame, parity frames
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].inst, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(vecs[i].inst, vecs[i].data, (vecs[i].inst == 1) ? 7 : 8,
                       (vecs[i].inst == 1) ? 2 : 0, 1, vecs[i].flip_par, 2'b11,
                       vecs[i].noise, -1);
        end
        repeat (20) @(negedge clk);
        chk("table_a_frames", 32'(vcnt[0]), 5);
        chk("table_b_frames", 32'(vcnt[1]), 3);

        // Glitch on idle line
        base = vcnt[0];
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            line_a = 1'b0;
            if (busy_a) seen = 1'b1;
        end
        repeat (40) begin
            @(negedge clk);
            line_a = 1'b1;
            if (busy_a) seen = 1'b1;
        end
        chk("glitch_busy_seen", 32'(seen), 1);
        chk("glitch_busy_cleared", 32'(busy_a), 0);
        chk("glitch_no_valid", 32'(vcnt[0] - base), 0);

        // Two stop bits, second one low, then a long break
        push(2, 9'h081, 1'b0, 1'b1);
        send_frame(2, 9'h081, 8, 0, 2, 1'b0, 2'b01, 1'b0, -1);
        base = vcnt[2];
        chk("break_frame_delivered", 32'(base), 1);
        repeat (40 * CPB) begin
            @(negedge clk);
            line_c = 1'b0;
        end
        chk("break_no_valid", 32'(vcnt[2] - base), 0);
        chk("break_not_busy", 32'(busy_c), 0);
        repeat (2 * CPB) begin
            @(negedge clk);
            line_c = 1'b1;
        end
        push(2, 9'h042, 1'b0, 1'b0);
        send_frame(2, 9'h042, 8, 0, 2, 1'b0, 2'b11, 1'b0, -1);
        repeat (5) @(negedge clk);
        chk("after_break_frame", 32'(vcnt[2] - base), 1);

        // Reset during data bit 4, then a clean frame
        base = vcnt[0];
        send_frame(0, 9'h096, 8, 0, 1, 1'b0, 2'b11, 1'b0, 5 * CPB + 10);
        line_a = 1'b1;
        repeat (300) @(negedge clk);
        chk("rst_mid_no_valid", 32'(vcnt[0] - base), 0);
        push(0, 9'h05A, 1'b0, 1'b0);
        send_frame(0, 9'h05A, 8, 0, 1, 1'b0, 2'b11, 1'b0, -1);
        repeat (5) @(negedge clk);
        chk("post_rst_frame", 32'(vcnt[0] - base), 1);

        // Every queued frame must have been delivered
        repeat (10) @(negedge clk);
        chk("a_queue_drained", 32'(q_a.size()), 0);
        chk("b_queue_drained", 32'(q_b.size()), 0);
        chk("c_queue_drained", 32'(q_c.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 receiver in the UART subsystem.
- Configurable clocks-per-bit, data width, parity mode and stop-bit count.
- Mid-bit 3-sample majority vote, false-start rejection, parity and framing error reporting.
- Sits between the asynchronous serial pin and the byte-consuming logic (loopback/TX or FIFO).

Parameters:
CLKS_PER_BIT, 29, system clocks per serial bit; legal range >= 8
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; synchronous, active-low
rs232  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received payload, LSB = first bit received
rx_valid  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity mismatch on the last frame; qualified by rx_valid
frame_err  output  1  any stop bit sampled low on the last frame; qualified by rx_valid
busy  output  1  high while the FSM is not IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE; baud/bit counters are set to 0.
  - Synchroniser flops s1/s2/s3 are set to 1.
  - rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Reset mid-frame abandons the frame with no rx_valid pulse.
- Input path:
  - rs232 -> s1 -> s2 (synchroniser), s3 = delayed s2.
  - Falling edge = !s2 & s3.
  - All sampling uses s2.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit index.
  - Runs only outside IDLE.
  - MID = CLKS_PER_BIT/2 (integer division).
- Bit decision:
  - s2 is sampled at cnt = MID-1, MID and MID+1.
  - The bit value is the majority of the 3 samples, decided at cnt = MID+1.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: on a falling edge go to START with cnt = 0 in the next cycle. busy goes high the same cycle START is entered.
  - START: at the decision point, if the majority is 1 (glitch), return to IDLE with no rx_valid and no flag change. Otherwise continue; at the wrap go to DATA, bit index 0.
  - DATA: store the decided bit into the shift register (LSB first). After DATA_BITS wraps go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: compute expected = XOR(data) for even, ~XOR(data) for odd. Mismatch with the decided bit sets the internal perr. At the wrap go to STOP.
  - STOP: a decided 0 on any stop bit sets the internal ferr.
    - For 2 stop bits, the first stop bit runs to its wrap.
    - At the decision point of the last stop bit, go to IDLE immediately (no wait for the bit end), so a start edge half a bit later is caught.
- Output update:
  - The cycle after the last stop-bit decision: rx_data <= shift register, parity_err <= perr, frame_err <= ferr, rx_valid = 1 for exactly one cycle.
  - perr/ferr are cleared on entering START.
  - rx_data and the flags hold until the next rx_valid.
  - Frames with errors still deliver data with rx_valid.
- Line held low after a frame error (break): no new frame until s2 has returned high and fallen again.
- No consumer handshake. A new frame overwrites rx_data; the consumer must capture it on rx_valid.
- Latency (default 8N1, CPB = 29):
  - Falling edge detected 3 cycles after rs232 falls; cnt = 0 in the next cycle.
  - Stop-bit decision at 9*29+15 = 276 cycles after cnt = 0.
  - rx_valid one cycle later, about 281 cycles after rs232 falls. Bench tolerance is ±2.

Test Plan:
- Default 8N1, send 0xA5 at 29 clk/bit -> rx_valid once in the window 279..283 cycles after the start edge; rx_data = 0xA5, parity_err = 0, frame_err = 0, busy low after the pulse.
- Back-to-back bytes 0x00, 0xFF, 0x3C with no idle gap -> three rx_valid pulses, data in order, no flags.
- 0.5 us-class glitch (6-cycle low pulse) on an idle line -> busy pulses high, returns to IDLE, no rx_valid.
- PARITY = 2, DATA_BITS = 7: send 0x55 with correct parity -> parity_err = 0; resend 0x55 with parity inverted -> rx_valid with rx_data = 0x55, parity_err = 1.
- STOP_BITS = 2: second stop bit driven 0 on byte 0x81 -> rx_data = 0x81, frame_err = 1. Line then held low for 40 bit times -> no further rx_valid until the line goes high and a new start arrives.
- Reset mid-frame: assert rst_n low during data bit 4 of 0x96 -> all outputs 0 next cycle, no rx_valid. A following frame 0x5A is received correctly.
- Noise tolerance: flip s2 for one cycle at cnt = MID on every bit of 0xC3 -> majority vote still yields 0xC3 with no flags.
